// File: rtl/rob_commit.sv
// rob_commit: in-order retire control for the reorder-buffer head (store drain, branch flush, commit strobe).
// Optional macro COMMIT_INSTRET_EN adds a 64-bit retired-instruction counter output named instret.
module rob_commit #(
  parameter int DW = 64,
  parameter int RW = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rob_empty,
  input  logic [DW-1:0]     rob_head,
  output logic              rob_pop,
  input  logic [2**RW-1:0]  wb_log,
  input  logic              bru_valid,
  input  logic              bru_mispredict,
  input  logic              csr_done,
  output logic              su_req,
  input  logic              su_ack,
  output logic              flush,
  output logic              commit_valid,
  output logic              commit_rd_valid,
  output logic [RW-1:0]     commit_rd
`ifdef COMMIT_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);
  localparam logic [1:0] RUN = 2'd0, WAIT_SU = 2'd1, FLUSH = 2'd2;
  logic [1:0] state, state_n;
  logic hold, en, ready, mispred;
  logic is_branch, is_csr, is_su, has_rd;
  logic [RW-1:0] rd;
  logic unused_bits;
  assign is_branch = rob_head[5];
  assign is_csr = rob_head[4];
  assign is_su = rob_head[3];
  assign has_rd = rob_head[1];
  assign rd = rob_head[RW+7:8];
  assign unused_bits = ^{rob_head[DW-1:RW+8], rob_head[7:6], rob_head[2], rob_head[0]};
  // hold keeps the handshake outputs quiet for the first cycle after reset
  assign en = !RST && !hold;
  assign ready = !rob_empty && (!has_rd || wb_log[rd]) && (!is_branch || bru_valid) && (!is_csr || csr_done);
  assign su_req = en && (state == WAIT_SU || (state == RUN && ready && is_su));
  assign rob_pop = en && !rob_empty &&
                   ((state == RUN && ready && (!is_su || su_ack)) || (state == WAIT_SU && su_ack));
  assign mispred = rob_pop && is_branch && bru_valid && bru_mispredict;
  assign flush = en && state == FLUSH;
  assign state_n = mispred ? FLUSH : (su_req && !rob_pop) ? WAIT_SU : RUN;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      hold <= 1'b1;
      commit_valid <= 1'b0;
      commit_rd_valid <= 1'b0;
      commit_rd <= '0;
    end else begin
      state <= state_n;
      hold <= 1'b0;
      commit_valid <= rob_pop;
      commit_rd_valid <= rob_pop && has_rd;
      commit_rd <= rob_pop ? rd : commit_rd;
    end
  end
`ifdef COMMIT_INSTRET_EN
  always_ff @(posedge CLK) begin
    if (RST) instret <= '0;
    else instret <= instret + {63'd0, rob_pop};
  end
`endif
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed retire scenarios plus randomized traffic checked against a behavioural model.
module tb_rob_commit;
  logic CLK = 1'b0, RST = 1'b1, rob_empty = 1'b1, bru_valid = 1'b0, bru_mispredict = 1'b0;
  logic csr_done = 1'b0, su_ack = 1'b0;
  logic [63:0] rob_head = '0, wb_log = '0;
  logic rob_pop, su_req, flush, commit_valid, commit_rd_valid;
  logic [5:0] commit_rd;
`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret;
`endif
  int tests = 0, fails = 0;

  rob_commit dut (
    .CLK(CLK), .RST(RST), .rob_empty(rob_empty), .rob_head(rob_head), .rob_pop(rob_pop),
    .wb_log(wb_log), .bru_valid(bru_valid), .bru_mispredict(bru_mispredict), .csr_done(csr_done),
    .su_req(su_req), .su_ack(su_ack), .flush(flush), .commit_valid(commit_valid),
    .commit_rd_valid(commit_rd_valid), .commit_rd(commit_rd)
`ifdef COMMIT_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, want %0h", n, $time, a, e);
    end
  endtask

  function automatic logic [63:0] mk(input bit br, input bit csr, input bit su, input bit hrd, input int r);
    logic [63:0] h;
    h = '0;
    h[5] = br; h[4] = csr; h[3] = su; h[1] = hrd; h[13:8] = r[5:0];
    return h;
  endfunction

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  // model: a pending store drain, a flush owed next cycle, and the quiet cycle after reset
  bit m_wait = 0, m_flush = 0, m_quiet = 0, e_cv = 0, e_crv = 0;
  logic [5:0] e_crd = '0;
  longint unsigned m_instret = 0;

  always @(negedge CLK) begin
    bit h_br, h_csr, h_su, h_rd, rdy, e_pop, e_su, e_fl;
    int r;
    h_br = rob_head[5]; h_csr = rob_head[4]; h_su = rob_head[3]; h_rd = rob_head[1];
    r = int'(rob_head[13:8]);
    rdy = !rob_empty && (!h_rd || wb_log[r]) && (!h_br || bru_valid) && (!h_csr || csr_done);
    e_pop = 0; e_su = 0; e_fl = 0;
    if (RST || m_quiet) ;
    else if (m_flush) e_fl = 1;
    else if (m_wait) begin e_su = 1; e_pop = su_ack && !rob_empty; end
    else begin e_su = rdy && h_su; e_pop = rdy && (!h_su || su_ack); end
    chk("rob_pop", rob_pop, e_pop);
    chk("su_req", su_req, e_su);
    chk("flush", flush, e_fl);
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_rd_valid", commit_rd_valid, e_crv);
    if (e_cv) chk("commit_rd", commit_rd, e_crd);
`ifdef COMMIT_INSTRET_EN
    chk("instret", instret, m_instret);
`endif
    if (RST) begin
      m_wait = 0; m_flush = 0; m_quiet = 1; e_cv = 0; e_crv = 0; e_crd = '0; m_instret = 0;
    end else begin
      m_quiet = 0;
      m_flush = e_pop && h_br && bru_valid && bru_mispredict;
      m_wait = e_su && !e_pop;
      e_cv = e_pop;
      e_crv = e_pop && h_rd;
      if (e_pop) e_crd = r[5:0];
      m_instret += e_pop ? 1 : 0;
    end
  end

  initial begin
    repeat (2) next();
    chk("rst_cv", commit_valid, 0);
    chk("rst_crd", commit_rd, 0);
    chk("rst_flush", flush, 0);
    RST = 0; rob_empty = 0; rob_head = mk(0, 0, 0, 0, 0);
    @(negedge CLK); chk("hold_pop", rob_pop, 0); next();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); chk("b2b_pop", rob_pop, 1); next();
    end
    rob_empty = 1;
`ifdef COMMIT_INSTRET_EN
    @(negedge CLK); chk("instret10", instret, 10);
`endif
    next();
    rob_empty = 0; rob_head = mk(0, 0, 0, 1, 5); wb_log = '0;
    repeat (3) begin @(negedge CLK); chk("rd_stall", rob_pop, 0); next(); end
    wb_log[5] = 1;
    @(negedge CLK); chk("rd_pop", rob_pop, 1); next();
    rob_empty = 1;
    @(negedge CLK); chk("rd_cv", commit_valid, 1); chk("rd_crd", commit_rd, 5); chk("rd_crv", commit_rd_valid, 1); next();
    rob_empty = 0; rob_head = mk(0, 0, 1, 0, 0); su_ack = 0;
    repeat (2) begin @(negedge CLK); chk("su_req_wait", su_req, 1); chk("su_nopop", rob_pop, 0); next(); end
    su_ack = 1;
    @(negedge CLK); chk("su_req_ack", su_req, 1); chk("su_pop", rob_pop, 1); next();
    su_ack = 0; rob_empty = 1;
    @(negedge CLK); chk("su_done", su_req, 0); chk("su_cv", commit_valid, 1); next();
    rob_empty = 0; rob_head = mk(1, 0, 0, 0, 0); bru_valid = 1; bru_mispredict = 1;
    @(negedge CLK); chk("br_pop", rob_pop, 1); next();
    bru_mispredict = 0;
    @(negedge CLK); chk("br_flush", flush, 1); chk("br_flush_nopop", rob_pop, 0); next();
    @(negedge CLK); chk("br_after_flush", flush, 0); chk("br_resume_pop", rob_pop, 1); next();
    rob_empty = 1; bru_valid = 0; wb_log = '1; rob_head = mk(0, 0, 0, 1, 7);
    @(negedge CLK); chk("empty_pop", rob_pop, 0); next();
    @(negedge CLK); chk("empty_cv", commit_valid, 0); next();
    rob_empty = 0; rob_head = mk(0, 0, 1, 0, 0);
    @(negedge CLK); chk("rst_su_entry", su_req, 1); next();
    RST = 1;
    @(negedge CLK); chk("rst_su_nopop", rob_pop, 0); next();
    RST = 0;
    @(negedge CLK); chk("rst_su_req", su_req, 0); chk("rst_su_pop", rob_pop, 0); next();
    rob_empty = 1;
    @(negedge CLK); chk("rst_su_run", su_req, 0); chk("rst_su_noflush", flush, 0); next();
    for (int i = 0; i < 3000; i++) begin
      RST = $urandom_range(63) == 0;
      rob_empty = $urandom_range(3) == 0;
      rob_head = {$urandom, $urandom};
      wb_log = {$urandom, $urandom} | {$urandom, $urandom};
      bru_valid = $urandom_range(1);
      bru_mispredict = $urandom_range(2) == 0;
      csr_done = $urandom_range(1);
      su_ack = $urandom_range(2) == 0;
      next();
    end
    RST = 0; rob_empty = 1;
    next();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
